// File: rtl/gap_pkg.sv
// Shared constants and controller state encoding for the gap scan arbiter.
package gap_pkg;

  localparam int W  = 32;
  localparam int GW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/gap_scan_arbiter_if.sv
// Requester-side bundle: request levels, words, and the per-requester ack/done pulses.
interface gap_scan_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = gap_pkg::W,
  parameter int GW   = gap_pkg::GW
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [GW-1:0]     result;
  logic              busy;

  modport master (output req, data, input ack, done, result, busy);
  modport slave  (input req, data, output ack, done, result, busy);

endinterface

// File: rtl/gap_scan_core.sv
// Serial LSB-first binary-gap engine: one bit per step, tracks the longest zero run bounded by ones.
module gap_scan_core
  import gap_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  word,
  input  logic          step,
  output logic [GW-1:0] gap,
  output logic          last
);

  logic [W-1:0]  shreg;
  logic          seen_one;
  logic [GW-1:0] run;
  logic [GW-1:0] best;
  logic [GW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      seen_one <= 1'b0;
      run      <= '0;
      best     <= '0;
      cnt      <= '0;
    end else if (load) begin
      shreg    <= word;
      seen_one <= 1'b0;
      run      <= '0;
      best     <= '0;
      cnt      <= '0;
    end else if (step) begin
      if (shreg[0]) begin
        if (seen_one && (run > best)) best <= run;
        run      <= '0;
        seen_one <= 1'b1;
      end else if (seen_one) begin
        run <= run + 1'b1;
      end
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  // Best value including the bit being consumed now, so the final bit's run
  // is visible in the same cycle the controller captures the result.
  assign gap  = (shreg[0] && seen_one && (run > best)) ? run : best;
  assign last = (cnt == GW'(W - 1));

endmodule

// File: rtl/gap_scan_arbiter.sv
// Round-robin front end that shares one gap_scan_core among NREQ requesters.
module gap_scan_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int GW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  gap_scan_arbiter_if.slave bus
);

  import gap_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ctrl_state_t   state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic          core_load;
  logic          core_step;
  logic          core_last;
  logic [GW-1:0] core_gap;

  // Scan downward so the lowest offset from ptr is the final assignment.
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr) + i) % NREQ]) winner = PW'((int'(ptr) + i) % NREQ);
    end
  end

  assign core_load = (state == IDLE) && (|bus.req);
  assign core_step = (state == SCAN);

  gap_scan_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .word (bus.data[winner*W +: W]),
    .step (core_step),
    .gap  (core_gap),
    .last (core_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      bus.ack    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
    end else begin
      bus.ack  <= '0;
      bus.done <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner    <= winner;
            bus.ack  <= NREQ'(1) << winner;
            bus.busy <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (core_last) begin
            bus.done   <= NREQ'(1) << owner;
            bus.result <= core_gap;
            state      <= REPORT;
          end
        end
        REPORT: begin
          ptr      <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gap_scan_arbiter.sv
// Directed bench for gap_scan_arbiter: single jobs, edge words, round-robin order, mid-scan reset.
module tb_gap_scan_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gap_scan_arbiter_if #(.NREQ(4), .W(32), .GW(5)) bus ();

  gap_scan_arbiter #(.NREQ(4), .W(32), .GW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete job from IDLE: ack one cycle after the request, done 32 cycles after ack.
  task automatic applyStimulus(input int r, input logic [31:0] w, input logic [4:0] g);
    int k;
    bus.data[r*32 +: 32] = w;
    bus.req[r] = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("ack_r%0d_%0h", r, w), bus.ack, 32'(4'b0001 << r));
    checkOutput($sformatf("busy_r%0d_%0h", r, w), bus.busy, 1);
    bus.req[r] = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done != 0) break;
    end
    checkOutput($sformatf("lat_r%0d_%0h", r, w), k, 32);
    checkOutput($sformatf("done_r%0d_%0h", r, w), bus.done, 32'(4'b0001 << r));
    checkOutput($sformatf("result_r%0d_%0h", r, w), bus.result, g);
    checkOutput($sformatf("noack_r%0d_%0h", r, w), bus.ack, 0);
    @(negedge clk);
    checkOutput($sformatf("idle_r%0d_%0h", r, w), bus.busy, 0);
  endtask

  task automatic waitAck(input string tag, input logic [3:0] exp);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.ack != 0) break;
    end
    checkOutput(tag, bus.ack, exp);
  endtask

  task automatic waitIdle(input string tag);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    checkOutput(tag, bus.busy, 0);
  endtask

  logic [31:0] rr_words [4] = '{32'h0000_0009, 32'h0000_0021, 32'h8000_0001, 32'h0000_0014};
  logic [4:0]  rr_gaps  [4] = '{5'd2, 5'd4, 5'd30, 5'd1};

  initial begin
    int nack;
    int ndone;
    int last_ack;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", bus.ack, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_result", bus.result, 0);
    checkOutput("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 32'h0000_0009, 5'd2);
    applyStimulus(1, 32'h8000_0001, 5'd30);
    applyStimulus(1, 32'h0000_0014, 5'd1);
    applyStimulus(0, 32'h0000_0000, 5'd0);
    applyStimulus(0, 32'hFFFF_FFFF, 5'd0);
    applyStimulus(0, 32'h0000_0001, 5'd0);
    applyStimulus(0, 32'h0000_0021, 5'd4);

    // All four requesters held high from reset release.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) bus.data[i*32 +: 32] = rr_words[i];
    bus.req = 4'hF;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    nack     = 0;
    ndone    = 0;
    last_ack = 0;
    for (int cyc = 0; cyc < 220 && nack < 5; cyc++) begin
      @(negedge clk);
      if (bus.ack != 0) begin
        checkOutput($sformatf("rr_ack%0d", nack), bus.ack, 32'(4'b0001 << (nack % 4)));
        if (nack > 0) checkOutput($sformatf("rr_gap%0d", nack), cyc - last_ack, 34);
        last_ack = cyc;
        nack++;
      end
      if (bus.done != 0) begin
        checkOutput($sformatf("rr_done%0d", ndone), bus.done, 32'(4'b0001 << (ndone % 4)));
        checkOutput($sformatf("rr_result%0d", ndone), bus.result, rr_gaps[ndone % 4]);
        ndone++;
      end
    end
    checkOutput("rr_acks", nack, 5);
    checkOutput("rr_dones", ndone, 4);
    bus.req = '0;
    waitIdle("rr_idle");
    @(negedge clk);

    // Reset in the middle of a scan discards the job.
    applyStimulus(1, 32'h0000_0021, 5'd4);
    bus.data[31:0] = 32'h0000_0009;
    bus.req[0] = 1'b1;
    @(negedge clk);
    checkOutput("mid_ack", bus.ack, 1);
    bus.req[0] = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ack", bus.ack, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_result", bus.result, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done != 0) ndone++;
    end
    checkOutput("mid_no_done", ndone, 0);
    applyStimulus(2, 32'h0000_0009, 5'd2);

    // Pointer behaviour: 3 owns -> ptr 0 picks 2; 2 owns -> ptr 3 picks 3 over 1.
    bus.data[96 +: 32] = 32'h0000_0021;
    bus.req[3] = 1'b1;
    waitAck("arb_first", 4'b1000);
    bus.req[3] = 1'b0;
    repeat (5) @(negedge clk);
    bus.data[64 +: 32] = 32'h0000_0009;
    bus.req[2] = 1'b1;
    bus.req[3] = 1'b1;
    waitAck("arb_ptr0", 4'b0100);
    bus.req[2] = 1'b0;
    bus.data[32 +: 32] = 32'h0000_0014;
    bus.req[1] = 1'b1;
    waitAck("arb_ptr3", 4'b1000);
    bus.req[3] = 1'b0;
    waitAck("arb_wrap", 4'b0010);
    bus.req = '0;
    waitIdle("arb_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gap_scan_arbiter.md
# gap_scan_arbiter

Shares one serial binary-gap scan engine among NREQ requesters. Each requester submits a 32-bit word through a req/ack handshake. The block arbitrates round-robin, loads the winner's word into the engine, and sequences a 32-cycle LSB-first scan. It then returns the longest bounded zero run to the owning requester with a done pulse. It sits between the requesting datapath units and the gap engine, and owns all scan scheduling.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, data word width (fixed at 32 in this revision)
- GW, 5, result width, $clog2(W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level
- data  in  NREQ*W  requester i word at data[i*W +: W], stable while req[i] high and until ack[i]
- ack  out  NREQ  one-cycle pulse: requester's word latched
- done  out  NREQ  one-cycle pulse: result valid for that requester
- result  out  GW  gap of the most recently completed job, held until next done
- busy  out  1  high whenever state is not IDLE

## Operation
- Gap definition: the longest run of consecutive 0s bounded by 1s on both sides, scanning bit 0 to bit 31. Leading zeros (before the first 1) and trailing zeros (after the last 1) are not counted. No bounded run gives a result of 0. The maximum result is 30.
- Controller FSM states:
  - IDLE: if req != 0, pick the winner, latch its word, pulse ack[winner], set owner = winner, and go to SCAN.
  - SCAN: 32 cycles, engine consumes bit k = 0..31; after k = 31, go to REPORT.
  - REPORT: pulse done[owner], load result, update the round-robin pointer, go to IDLE.
- Arbitration: the winner is the first asserted req at or after ptr, wrapping modulo NREQ. ptr = owner+1 mod NREQ after REPORT. Requests are sampled only in IDLE.
- Engine algorithm, per bit:
  - bit = 1: if seen_one, best = max(best, run); then run = 0 and seen_one = 1.
  - bit = 0: if seen_one, run = run + 1.
  - run, best, and the bit counter are GW bits wide. run cannot exceed 31, so there is no overflow.
  - Engine state clears on the load from IDLE.
- A req still high when the controller returns to IDLE counts as a new request for the same requester.
- Reset values: ack = 0, done = 0, result = 0, busy = 0, state = IDLE, ptr = 0, owner = 0, and all engine registers 0.
- Reset mid-operation discards the in-flight job. No done is issued, and the requester must re-request.

## Timing
- req[i] seen in IDLE in cycle t:
  - ack[i] is high in cycle t+1, registered.
  - SCAN occupies cycles t+1..t+32.
  - REPORT is cycle t+33, with done[i] = 1 and result valid.
  - IDLE resumes in t+34.
- Request-to-done latency is 33 cycles. Throughput is one job per 34 cycles.
- ack and done are never high in the same cycle. At most one bit of ack or done is set at a time.
- result changes only in the cycle done is asserted.
- busy is high in cycles t+1..t+33.

## Structure
- Shared package gap_pkg holds:
  - constants W = 32 and GW = 5;
  - controller state encoding IDLE = 0, SCAN = 1, REPORT = 2.
- Sub-module gap_scan_core holds the serial engine:
  - inputs: clk, rst, load, word[W-1:0], step;
  - outputs: gap[GW-1:0], last (high when the bit counter is 31).
  - It holds the shift register, seen_one, run, best, and the bit counter.
- The top level holds the FSM, round-robin pointer, owner register, ack/done generation, and result register.

## Test plan
- Single requester 0, data 0x00000009 -> ack[0] at t+1, done[0] at t+33, result = 2.
- Requester 1, data 0x80000001 -> result = 30. Requester 1, data 0x00000014 -> result = 1 (trailing and leading zeros ignored).
- Edge words:
  - 0x00000000 -> 0;
  - 0xFFFFFFFF -> 0;
  - 0x00000001 -> 0;
  - 0x00000021 -> 4.
- All four reqs held high from reset release -> ack order 0,1,2,3,0 at 34-cycle spacing. Each done carries its own word's gap.
- rst pulsed at SCAN cycle 15 of a job -> all outputs 0, no done. A request after release completes normally in 33 cycles.
- req[2] and req[3] raised while busy with requester 3 owning (ptr = 0 afterwards) -> next grant goes to 2. With ptr = 3 and reqs 1 and 3 pending -> grant goes to 3.
